// File: rtl/ei_mac10_feeder.sv
// Job-level sequencer for the 10-lane 8x8 dot-product MAC: streams chunks in,
// collects per-chunk sums and presents a 32-bit job total with a sticky wrap flag.
module ei_mac10_feeder #(
   parameter int unsigned LAT   = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_start,
   input  logic [CNT_W-1:0]  job_len,
   output logic              job_busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [79:0]       in_a,
   input  logic [79:0]       in_b,
   output logic              mac_en,
   output logic              mac_valid_in,
   output logic              mac_clr_acc,
   output logic [79:0]       mac_a_vec,
   output logic [79:0]       mac_b_vec,
   input  logic              mac_valid_out,
   input  logic [31:0]       mac_acc_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [31:0]       res_data,
   output logic              res_ovf
);

   if (LAT == 0) begin : g_lat_chk
      $error("ei_mac10_feeder: LAT must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] len_q, issued_q, collected_q;
   logic [31:0]      total_q;
   logic             ovf_q;
   logic             cap_pend_q;
   logic             mac_en_q, mac_valid_in_q, mac_clr_acc_q;
   logic [79:0]      mac_a_q, mac_b_q;
   logic             res_valid_q;
   logic [31:0]      res_data_q;

   logic             xfer;
   logic [32:0]      sum_d;
   logic             capture_d;
   logic             last_cap_d;

   assign in_ready = (state_q == FEED) && (issued_q != len_q);
   assign xfer     = in_valid && in_ready;
   assign job_busy = (state_q != IDLE);

   // mac_acc_out is only meaningful the cycle after mac_valid_out, hence cap_pend.
   always_comb begin
      sum_d      = {1'b0, total_q} + {1'b0, mac_acc_out};
      capture_d  = cap_pend_q && ((state_q == FEED) || (state_q == DRAIN));
      last_cap_d = capture_d && (collected_q == len_q - ONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         len_q          <= '0;
         issued_q       <= '0;
         collected_q    <= '0;
         total_q        <= '0;
         ovf_q          <= 1'b0;
         cap_pend_q     <= 1'b0;
         mac_en_q       <= 1'b1;
         mac_valid_in_q <= 1'b0;
         mac_clr_acc_q  <= 1'b0;
         mac_a_q        <= '0;
         mac_b_q        <= '0;
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
      end else begin
         mac_en_q       <= 1'b1;
         cap_pend_q     <= mac_valid_out;
         mac_valid_in_q <= xfer;
         mac_clr_acc_q  <= 1'b0;

         if (xfer) begin
            mac_a_q  <= in_a;
            mac_b_q  <= in_b;
            issued_q <= issued_q + ONE;
         end

         if (capture_d) begin
            total_q     <= sum_d[31:0];
            collected_q <= collected_q + ONE;
            if (sum_d[32]) begin
               ovf_q <= 1'b1;
            end
         end

         case (state_q)
            IDLE: begin
               if (job_start) begin
                  len_q       <= job_len;
                  total_q     <= '0;
                  ovf_q       <= 1'b0;
                  issued_q    <= '0;
                  collected_q <= '0;
                  if (job_len == '0) begin
                     state_q     <= DONE;
                     res_valid_q <= 1'b1;
                     res_data_q  <= '0;
                  end else begin
                     state_q       <= CLEAR;
                     mac_clr_acc_q <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               state_q <= FEED;
            end
            FEED: begin
               if (xfer && (issued_q == len_q - ONE)) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_cap_d) begin
                  state_q     <= DONE;
                  res_valid_q <= 1'b1;
                  res_data_q  <= sum_d[31:0];
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_q     <= IDLE;
                  res_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mac_en       = mac_en_q;
   assign mac_valid_in = mac_valid_in_q;
   assign mac_clr_acc  = mac_clr_acc_q;
   assign mac_a_vec    = mac_a_q;
   assign mac_b_vec    = mac_b_q;
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign res_ovf      = ovf_q;

endmodule

// File: doc/ei_mac10_feeder.md
Name: ei_mac10_feeder

Overview:
- Job-level sequencer that drives the 10-lane 8x8 dot-product MAC (ei_mac10_8x8_pipe) and collects its results.
- Accepts a job of N chunks; each chunk is 10 a-bytes and 10 b-bytes.
- Streams the chunks into the MAC, captures each per-chunk sum the MAC returns, and accumulates the sums into a 32-bit job total.
- Presents the job total on a valid/ready result port.
- The MAC only registers the latest chunk sum; cross-chunk accumulation is owned by this block.

Parameters:
- LAT, 3, multiplier latency configured on the attached MAC; must match the MAC instance.
- CNT_W, 16, width of the job length and the chunk counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- job_start  in  1  one-cycle pulse; starts a job; honoured only in IDLE
- job_len  in  CNT_W  chunk count; sampled when job_start is honoured
- job_busy  out  1  high whenever state is not IDLE
- in_valid  in  1  operand chunk valid
- in_ready  out  1  block can accept a chunk
- in_a  in  80  10 unsigned bytes; lane k = bits [8k+7:8k]
- in_b  in  80  10 unsigned bytes; same lane layout as in_a
- mac_en  out  1  MAC enable
- mac_valid_in  out  1  MAC valid_in
- mac_clr_acc  out  1  MAC clr_acc
- mac_a_vec  out  80  MAC a_vec
- mac_b_vec  out  80  MAC b_vec
- mac_valid_out  in  1  MAC valid_out
- mac_acc_out  in  32  MAC acc_out
- res_valid  out  1  job result valid
- res_ready  in  1  downstream accepts the result
- res_data  out  32  job total, modulo 2^32
- res_ovf  out  1  sticky flag: the 32-bit total wrapped during the job

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state = IDLE; all counters = 0; total = 0.
  - All outputs = 0, except mac_en = 1.
  - Reset mid-job abandons the job with no result.
  - The MAC shares clk and rst_n, so nothing is in flight after reset.
- mac_en is held at 1 after reset; this block never stalls the MAC.
- All mac_* outputs and all res_* outputs are registered.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - On job_start: latch len = job_len; clear total, res_ovf, issued and collected.
  - If job_len = 0, go to DONE with res_data = 0.
  - Otherwise go to CLEAR.
  - job_start in any other state is ignored.
- CLEAR:
  - Assert mac_clr_acc for exactly one cycle, then go to FEED.
- FEED:
  - in_ready = 1 while issued < len.
  - A transfer occurs on in_valid & in_ready. On a transfer:
    - the next cycle drives mac_a_vec = in_a, mac_b_vec = in_b, mac_valid_in = 1;
    - issued increments.
  - mac_valid_in is 0 in any cycle with no transfer on the previous edge.
  - mac_a_vec and mac_b_vec hold their last value when idle.
  - in_valid gaps are allowed; one chunk per cycle sustained.
  - When the transfer that makes issued = len completes, drop in_ready and go to DRAIN.
- Capture rule (FEED and DRAIN):
  - mac_valid_out high at cycle t means mac_acc_out holds that chunk's sum at cycle t+1.
  - Register mac_valid_out once (cap_pend).
  - When cap_pend = 1: total <= total + mac_acc_out (33-bit add); collected increments; a carry sets res_ovf.
  - End-to-end: a chunk accepted at edge 0 is added into total at edge LAT+3.
- DRAIN:
  - Go to DONE on the edge where the capture making collected = len occurs.
  - res_data = total including that last chunk.
- DONE:
  - res_valid = 1; res_data and res_ovf are stable while res_valid = 1.
  - On res_valid & res_ready: go to IDLE and clear res_valid at the next edge.
  - res_ready held low holds DONE indefinitely.
- Arithmetic:
  - Products are unsigned 16-bit; the MAC returns a zero-extended 32-bit chunk sum (max 650250).
  - The total wraps modulo 2^32; res_ovf is sticky for the job.
- job_busy = (state != IDLE).
- Back-to-back jobs: job_start is accepted on the cycle after the DONE handshake.

Test Plan:
- Reset, then hold rst_n=1 with no stimulus -> all outputs 0 except mac_en=1; job_busy=0; no mac_valid_in.
- job_len=1; in_a = ten 0x01 bytes; in_b = ten 0x02 bytes -> exactly one mac_clr_acc pulse; one mac_valid_in pulse; res_valid with res_data=20, res_ovf=0; total updated at edge LAT+3 after the accept.
- job_len=3; all bytes 0xFF; in_valid toggled 1,0,1,0,1 -> res_data=1950750; in_ready low after the 3rd transfer; exactly 3 captures.
- job_len=6606; all bytes 0xFF -> res_data=584204, res_ovf=1.
- job_len=0 -> DONE reached with no mac_valid_in and no mac_clr_acc; res_data=0.
- res_ready held low 10 cycles with a second job_start pulsed during DONE -> result held stable; second start ignored; after the handshake, a new job_start is accepted and its result is correct.
- rst_n asserted during DRAIN of a job_len=4 job -> IDLE, outputs at reset values; the next job_len=1 job returns the correct sum with no leftover captures.
